// File: rtl/seg7_scan_driver.sv
// Time-multiplexed N-digit 7-segment driver.
// A shadow register takes loads at any time. The active register that feeds the
// display is refreshed only at frame start, so one frame never mixes two loads.
// Each digit slot opens with a few cycles of all-anodes-off to suppress ghosting.
module seg7_scan_driver #(
  parameter int NUM_DIGITS     = 4,
  parameter int SCAN_DIV       = 1000,
  parameter int BLANK_CYCLES   = 8,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit AN_ACTIVE_LOW  = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en_i,
  input  logic                    load_i,
  input  logic [4*NUM_DIGITS-1:0] bcd_i,
  input  logic [NUM_DIGITS-1:0]   dp_i,
  input  logic                    lzb_i,
  input  logic                    hex_mode_i,
  output logic [6:0]              seg_o,
  output logic                    dp_o,
  output logic [NUM_DIGITS-1:0]   an_o,
  output logic                    frame_o
);

  localparam int PW = $clog2(SCAN_DIV);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
  localparam logic [PW-1:0] BLANK_LIM  = PW'(BLANK_CYCLES);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

  localparam logic [6:0]            SEG_OFF = {7{SEG_ACTIVE_LOW}};
  localparam logic                  DP_OFF  = SEG_ACTIVE_LOW;
  localparam logic [NUM_DIGITS-1:0] AN_OFF  = {NUM_DIGITS{AN_ACTIVE_LOW}};

  logic [PW-1:0]             presc;
  logic [IW-1:0]             idx;
  logic [4*NUM_DIGITS-1:0]   shadow_bcd;
  logic [NUM_DIGITS-1:0]     shadow_dp;
  logic [4*NUM_DIGITS-1:0]   active_bcd;
  logic [NUM_DIGITS-1:0]     active_dp;

  logic                      frame_start;
  logic [4*NUM_DIGITS-1:0]   view_bcd;
  logic [NUM_DIGITS-1:0]     view_dp;
  logic [3:0]                cur_nib;
  logic                      cur_dp;
  logic                      cur_blank;
  logic                      zero_run;
  logic [NUM_DIGITS-1:0]     an_lit;
  logic [6:0]                seg_lit;
  logic [6:0]                seg_next;
  logic                      dp_next;
  logic [NUM_DIGITS-1:0]     an_next;

  // Active-high glyph for one nibble; codes above 9 become a dash unless hex is on.
  function automatic logic [6:0] glyph(input logic [3:0] nib, input logic hex);
    logic [6:0] g;
    case (nib)
      4'h0:    g = 7'h3F;
      4'h1:    g = 7'h06;
      4'h2:    g = 7'h5B;
      4'h3:    g = 7'h4F;
      4'h4:    g = 7'h66;
      4'h5:    g = 7'h6D;
      4'h6:    g = 7'h7D;
      4'h7:    g = 7'h07;
      4'h8:    g = 7'h7F;
      4'h9:    g = 7'h6F;
      4'hA:    g = 7'h77;
      4'hB:    g = 7'h7C;
      4'hC:    g = 7'h39;
      4'hD:    g = 7'h5E;
      4'hE:    g = 7'h79;
      default: g = 7'h71;
    endcase
    if (nib > 4'h9 && !hex) begin
      g = 7'h40;
    end
    return g;
  endfunction

  // A frame starts whenever the scan sits at digit 0, count 0 while enabled;
  // disable forces that position, so the first enabled cycle is a frame start.
  assign frame_start = en_i && (presc == '0) && (idx == '0);

  // Slot prescaler and digit index; both held at zero while scanning is disabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc <= '0;
      idx   <= '0;
    end else if (!en_i) begin
      presc <= '0;
      idx   <= '0;
    end else if (presc == PRESC_LAST) begin
      presc <= '0;
      idx   <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
    end else begin
      presc <= presc + 1'b1;
    end
  end

  // Shadow register: takes every load strobe, independent of the scan.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_bcd <= '0;
      shadow_dp  <= '0;
    end else if (load_i) begin
      shadow_bcd <= bcd_i;
      shadow_dp  <= dp_i;
    end
  end

  // Active register: refreshed from the pre-load shadow only at frame start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_bcd <= '0;
      active_dp  <= '0;
    end else if (frame_start) begin
      active_bcd <= shadow_bcd;
      active_dp  <= shadow_dp;
    end
  end

  // Next display value for the current scan position, including leading-zero blanking.
  always_comb begin
    view_bcd  = frame_start ? shadow_bcd : active_bcd;
    view_dp   = frame_start ? shadow_dp  : active_dp;
    cur_nib   = 4'h0;
    cur_dp    = 1'b0;
    cur_blank = 1'b0;
    zero_run  = 1'b1;
    an_lit    = '0;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      zero_run  = zero_run && (view_bcd[4*k +: 4] == 4'h0);
      an_lit[k] = (idx == IW'(k));
      if (idx == IW'(k)) begin
        cur_nib   = view_bcd[4*k +: 4];
        cur_dp    = view_dp[k];
        cur_blank = lzb_i && zero_run && (k != 0);
      end
    end
    seg_lit = cur_blank ? 7'h00 : glyph(cur_nib, hex_mode_i);
    if (!en_i || (presc < BLANK_LIM)) begin
      seg_next = SEG_OFF;
      dp_next  = DP_OFF;
      an_next  = AN_OFF;
    end else begin
      seg_next = seg_lit ^ SEG_OFF;
      dp_next  = cur_dp ^ DP_OFF;
      an_next  = an_lit ^ AN_OFF;
    end
  end

  // Registered pins; frame_o lines up with the first displayed cycle of a new frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_o   <= SEG_OFF;
      dp_o    <= DP_OFF;
      an_o    <= AN_OFF;
      frame_o <= 1'b0;
    end else begin
      seg_o   <= seg_next;
      dp_o    <= dp_next;
      an_o    <= an_next;
      frame_o <= frame_start;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver (4 digits, 4-cycle slots, 1 blank cycle, active-low pins).
// Stimulus pushes the hand-computed glyph of every slot of a frame; the monitor pops one
// entry each time a digit slot turns on and compares the anode, segment and dp pins.
module tb_seg7_scan_driver;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en_i;
  logic        load_i;
  logic [15:0] bcd_i;
  logic [3:0]  dp_i;
  logic        lzb_i;
  logic        hex_mode_i;
  logic [6:0]  seg_o;
  logic        dp_o;
  logic [3:0]  an_o;
  logic        frame_o;

  seg7_scan_driver #(
    .NUM_DIGITS(4), .SCAN_DIV(4), .BLANK_CYCLES(1),
    .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en_i(en_i), .load_i(load_i), .bcd_i(bcd_i),
    .dp_i(dp_i), .lzb_i(lzb_i), .hex_mode_i(hex_mode_i), .seg_o(seg_o),
    .dp_o(dp_o), .an_o(an_o), .frame_o(frame_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
  } slot_t;

  typedef struct {
    int          kind;
    string       name;
    logic [12:0] want;
    int          got_i;
    int          want_i;
  } chk_t;

  typedef struct packed {
    logic        lzb;
    logic        hex;
    logic [27:0] glyphs;
    logic [3:0]  dpx;
    logic [1:0]  kind;
    logic [15:0] ld;
    logic [3:0]  ldp;
  } frame_t;

  slot_t  expq[$];
  chk_t   stq[$];
  frame_t tbl[$];
  event   chk_ev;
  int     compared = 0;
  int     mismatched = 0;
  int     cyc = 0;
  int     last_frame = -1;
  logic [3:0] prev_an = 4'hF;

  // Free-running cycle count, used to measure frame spacing.
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: point checks queued by the stimulus, plus one scoreboard pop per digit slot.
  always @(negedge clk or chk_ev) begin
    if (stq.size() > 0) begin
      chk_t c;
      c = stq.pop_front();
      compared++;
      if (c.kind == 0) begin
        if ({an_o, seg_o, dp_o, frame_o} !== c.want) begin
          mismatched++;
          $display("[TB] FAIL %s: got an=%b seg=%h dp=%b frame=%b, want an=%b seg=%h dp=%b frame=%b",
                   c.name, an_o, seg_o, dp_o, frame_o, c.want[12:9], c.want[8:2], c.want[1], c.want[0]);
        end
      end else if (c.kind == 1) begin
        if (c.got_i != c.want_i) begin
          mismatched++;
          $display("[TB] FAIL %s: got %0d, want %0d", c.name, c.got_i, c.want_i);
        end
      end else begin
        if (expq.size() != 0) begin
          mismatched++;
          $display("[TB] FAIL %s: %0d slots never shown, want 0", c.name, expq.size());
        end
      end
    end else if (!clk) begin
      if (an_o != 4'hF && prev_an == 4'hF) begin
        compared++;
        if (expq.size() == 0) begin
          mismatched++;
          $display("[TB] FAIL slot: got an=%b seg=%h dp=%b, want no slot", an_o, seg_o, dp_o);
        end else begin
          slot_t e;
          e = expq.pop_front();
          if ({an_o, seg_o, dp_o} !== e) begin
            mismatched++;
            $display("[TB] FAIL slot: got an=%b seg=%h dp=%b, want an=%b seg=%h dp=%b",
                     an_o, seg_o, dp_o, e.an, e.seg, e.dp);
          end
        end
      end
      prev_an = an_o;
    end
  end

  task automatic checkOutput(input string name, input logic [3:0] an, input logic [6:0] seg,
                             input logic dp, input logic fr);
    chk_t c;
    c.kind = 0; c.name = name; c.want = {an, seg, dp, fr}; c.got_i = 0; c.want_i = 0;
    stq.push_back(c);
    #1 -> chk_ev;
    #1;
  endtask

  task automatic checkValue(input string name, input int got, input int want, input int kind);
    chk_t c;
    c.kind = kind; c.name = name; c.want = '0; c.got_i = got; c.want_i = want;
    stq.push_back(c);
    #1 -> chk_ev;
    #1;
  endtask

  // One-cycle load strobe starting right after a falling edge.
  task automatic applyStimulus(input logic [15:0] bcd, input logic [3:0] dp);
    bcd_i  = bcd;
    dp_i   = dp;
    load_i = 1'b1;
    @(negedge clk);
    load_i = 1'b0;
  endtask

  // Queue the expected slots of one frame (glyphs packed {d3,d2,d1,d0}, active-high).
  task automatic pushFrame(input logic [27:0] glyphs, input logic [3:0] dpx, input int nslots);
    slot_t s;
    logic [6:0] g;
    logic [3:0] one;
    one = 4'b0001;
    for (int k = 0; k < nslots; k++) begin
      g     = glyphs[7*k +: 7];
      s.an  = ~(one << k);
      s.seg = ~g;
      s.dp  = ~dpx[k];
      expq.push_back(s);
    end
  endtask

  // Wait (bounded) for frame_o, optionally checking the spacing from the previous one.
  task automatic waitFrame(input bit chk_period);
    int n;
    n = 0;
    while (!frame_o && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!frame_o) begin
      checkValue("frame_timeout", 0, 1, 1);
    end else begin
      if (chk_period && last_frame >= 0) checkValue("frame_period", cyc - last_frame, 16, 1);
      last_frame = cyc;
    end
  endtask

  task automatic addFrame(input logic lzb, input logic hex, input logic [27:0] glyphs,
                          input logic [3:0] dpx, input logic [1:0] kind,
                          input logic [15:0] ld, input logic [3:0] ldp);
    frame_t f;
    f.lzb = lzb; f.hex = hex; f.glyphs = glyphs; f.dpx = dpx;
    f.kind = kind; f.ld = ld; f.ldp = ldp;
    tbl.push_back(f);
  endtask

  // Watchdog so a stuck design still ends the run.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got no finish, want finish before timeout");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    frame_t f;
    // kind: 0 none, 1 load mid-frame, 2 load in the next frame-start cycle
    addFrame(0, 0, {7'h06, 7'h5B, 7'h4F, 7'h66}, 4'b0000, 2'd1, 16'h00AF, 4'b0000);
    addFrame(0, 1, {7'h3F, 7'h3F, 7'h77, 7'h71}, 4'b0000, 2'd0, 16'h0000, 4'b0000);
    addFrame(0, 0, {7'h3F, 7'h3F, 7'h40, 7'h40}, 4'b0000, 2'd1, 16'h0050, 4'b0000);
    addFrame(1, 0, {7'h00, 7'h00, 7'h6D, 7'h3F}, 4'b0000, 2'd1, 16'h0000, 4'b0000);
    addFrame(1, 0, {7'h00, 7'h00, 7'h00, 7'h3F}, 4'b0000, 2'd1, 16'h1111, 4'b0000);
    addFrame(0, 0, {7'h06, 7'h06, 7'h06, 7'h06}, 4'b0000, 2'd1, 16'h2222, 4'b0000);
    addFrame(0, 0, {7'h5B, 7'h5B, 7'h5B, 7'h5B}, 4'b0000, 2'd2, 16'h3333, 4'b0100);
    addFrame(0, 0, {7'h5B, 7'h5B, 7'h5B, 7'h5B}, 4'b0000, 2'd0, 16'h0000, 4'b0000);
    addFrame(0, 0, {7'h4F, 7'h4F, 7'h4F, 7'h4F}, 4'b0100, 2'd0, 16'h0000, 4'b0000);

    rst_n = 1'b0; en_i = 1'b0; load_i = 1'b0; bcd_i = '0; dp_i = '0;
    lzb_i = 1'b0; hex_mode_i = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("reset_state", 4'hF, 7'h7F, 1'b1, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(16'h1234, 4'b0000);
    en_i = 1'b1;

    foreach (tbl[i]) begin
      f = tbl[i];
      waitFrame(i > 0);
      lzb_i      = f.lzb;
      hex_mode_i = f.hex;
      pushFrame(f.glyphs, f.dpx, 4);
      if (f.kind == 2'd1) begin
        repeat (6) @(negedge clk);
        applyStimulus(f.ld, f.ldp);
      end else if (f.kind == 2'd2) begin
        repeat (15) @(negedge clk);
        applyStimulus(f.ld, f.ldp);
      end else begin
        @(negedge clk);
      end
    end

    waitFrame(1'b1);
    en_i = 1'b0;
    @(negedge clk);
    checkOutput("disable_next_edge", 4'hF, 7'h7F, 1'b1, 1'b0);
    applyStimulus(16'h0987, 4'b0001);
    repeat (3) @(negedge clk);
    checkOutput("disabled_hold", 4'hF, 7'h7F, 1'b1, 1'b0);
    lzb_i = 1'b0; hex_mode_i = 1'b0;
    en_i = 1'b1;
    @(negedge clk);
    checkOutput("reenable_frame", 4'hF, 7'h7F, 1'b1, 1'b1);
    last_frame = cyc;
    pushFrame({7'h3F, 7'h6F, 7'h7F, 7'h07}, 4'b0001, 4);
    @(negedge clk);

    waitFrame(1'b1);
    pushFrame({7'h3F, 7'h6F, 7'h7F, 7'h07}, 4'b0001, 1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    checkOutput("async_reset", 4'hF, 7'h7F, 1'b1, 1'b0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    last_frame = -1;
    waitFrame(1'b0);
    pushFrame({7'h3F, 7'h3F, 7'h3F, 7'h3F}, 4'b0000, 4);
    @(negedge clk);
    waitFrame(1'b1);
    en_i = 1'b0;
    @(negedge clk);
    checkValue("scoreboard_drained", 0, 0, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
